// File: rtl/registro_universal_param_pkg.sv
// Shared operating modes, shift directions and cell mux selects for the
// parametrised universal shift register.
package registro_universal_param_pkg;

  typedef enum logic [1:0] {
    MODO_DESP  = 2'b00,
    MODO_ROT   = 2'b01,
    MODO_CARGA = 2'b10,
    MODO_RET   = 2'b11
  } modo_e;

  localparam logic DIR_DER = 1'b0;
  localparam logic DIR_IZQ = 1'b1;

  // Cell select: "izq" takes the higher-index neighbour, "der" the lower one.
  typedef enum logic [1:0] {
    SEL_RET   = 2'b00,
    SEL_IZQ   = 2'b01,
    SEL_DER   = 2'b10,
    SEL_CARGA = 2'b11
  } sel_e;

endpackage

// File: rtl/registro_universal_param_celda_universal.sv
// One register bit: a flop plus a 4:1 next-value mux over
// hold / left neighbour / right neighbour / parallel data.
module celda_universal
  import registro_universal_param_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  sel_e sel,
  input  logic izq_in,
  input  logic der_in,
  input  logic d_in,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (sel)
      SEL_RET:   q_d = q_q;
      SEL_IZQ:   q_d = izq_in;
      SEL_DER:   q_d = der_in;
      SEL_CARGA: q_d = d_in;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/registro_universal_param.sv
// N-bit universal shift register built from celda_universal bits, with a
// frame counter that pulses fin for one cycle after every N shifts/rotates.
module registro_universal_param
  import registro_universal_param_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enb,
  input  logic [1:0]    modo,
  input  logic          dir,
  input  logic          s_in,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q,
  output logic          s_out,
  output logic [CW-1:0] cuenta,
  output logic          fin
);

  sel_e          sel;
  logic          borde_izq;
  logic          borde_der;
  logic [CW-1:0] cuenta_q;
  logic [CW-1:0] cuenta_d;
  logic          fin_q;
  logic          fin_d;
  logic          desplaza;

  always_comb begin
    sel      = SEL_RET;
    desplaza = 1'b0;
    if (enb) begin
      case (modo_e'(modo))
        MODO_DESP, MODO_ROT: begin
          sel      = (dir == DIR_DER) ? SEL_IZQ : SEL_DER;
          desplaza = 1'b1;
        end
        MODO_CARGA: sel = SEL_CARGA;
        MODO_RET:   sel = SEL_RET;
        default:    sel = SEL_RET;
      endcase
    end
  end

  // Edge bits: in rotate the opposite end wraps around, otherwise s_in enters.
  assign borde_izq = (modo_e'(modo) == MODO_ROT) ? q[0]   : s_in;
  assign borde_der = (modo_e'(modo) == MODO_ROT) ? q[N-1] : s_in;

  for (genvar i = 0; i < N; i++) begin : g_celda
    logic izq_in;
    logic der_in;

    if (i == N - 1) begin : g_msb
      assign izq_in = borde_izq;
    end else begin : g_izq
      assign izq_in = q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign der_in = borde_der;
    end else begin : g_der
      assign der_in = q[i-1];
    end

    celda_universal u_celda (
      .clk    (clk),
      .reset  (reset),
      .sel    (sel),
      .izq_in (izq_in),
      .der_in (der_in),
      .d_in   (d[i]),
      .q      (q[i])
    );
  end

  // fin defaults low so it can only ever be a single-cycle pulse.
  always_comb begin
    cuenta_d = cuenta_q;
    fin_d    = 1'b0;
    if (enb) begin
      if (desplaza) begin
        if (cuenta_q == CW'(N - 1)) begin
          cuenta_d = '0;
          fin_d    = 1'b1;
        end else begin
          cuenta_d = cuenta_q + CW'(1);
        end
      end else if (modo_e'(modo) == MODO_CARGA) begin
        cuenta_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta_q <= '0;
      fin_q    <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      fin_q    <= fin_d;
    end
  end

  assign cuenta = cuenta_q;
  assign fin    = fin_q;
  assign s_out  = (dir == DIR_IZQ) ? q[N-1] : q[0];

endmodule

// File: tb/tb_registro_universal_param.sv
// Self-checking bench for registro_universal_param (N=4): hand-derived vector
// table for the directed scenarios, then a randomised run against a model.
module tb_registro_universal_param;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk;
  logic          reset;
  logic          enb;
  logic [1:0]    modo;
  logic          dir;
  logic          s_in;
  logic [N-1:0]  d;
  logic [N-1:0]  q;
  logic          s_out;
  logic [CW-1:0] cuenta;
  logic          fin;

  registro_universal_param #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .enb    (enb),
    .modo   (modo),
    .dir    (dir),
    .s_in   (s_in),
    .d      (d),
    .q      (q),
    .s_out  (s_out),
    .cuenta (cuenta),
    .fin    (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          en;
    logic [1:0]    modo;
    logic          dir;
    logic          sin;
    logic [N-1:0]  d;
    logic [N-1:0]  eq;
    logic [CW-1:0] ec;
    logic          ef;
  } vec_t;

  typedef struct {
    logic [N-1:0]  q;
    logic [CW-1:0] c;
    logic          f;
    logic          so;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  logic [N-1:0]  m_q;
  logic [CW-1:0] m_c;
  logic          m_f;

  task automatic add_vec(input logic rst, input logic en, input logic [1:0] mo,
                         input logic dr, input logic si, input logic [N-1:0] dd,
                         input logic [N-1:0] eq, input logic [CW-1:0] ec,
                         input logic ef);
    vec_t v;
    v.rst = rst; v.en = en; v.modo = mo; v.dir = dr; v.sin = si; v.d = dd;
    v.eq = eq; v.ec = ec; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %b expected %b", name, step, got, exp);
    end
  endtask

  // Pops the oldest expectation and compares it with what the DUT shows now.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard step %0d: got empty queue expected an entry", step);
      return;
    end
    e = sb.pop_front();
    cmp("q",      q,                e.q);
    cmp("cuenta", N'(cuenta),       N'(e.c));
    cmp("fin",    N'(fin),          N'(e.f));
    cmp("s_out",  N'(s_out),        N'(e.so));
  endtask

  // Drives one cycle of inputs, queues the expected result, checks after the edge.
  task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] mo,
                               input logic dr, input logic si, input logic [N-1:0] dd,
                               input logic [N-1:0] eq, input logic [CW-1:0] ec,
                               input logic ef);
    exp_t e;
    @(negedge clk);
    if (en && $isunknown(mo)) begin
      checks++;
      errors++;
      $display("[TB] FAIL modo_x step %0d: got %b expected a defined mode", step, mo);
    end
    reset = rst; enb = en; modo = mo; dir = dr; s_in = si; d = dd;
    e.q = eq; e.c = ec; e.f = ef;
    e.so = dr ? eq[N-1] : eq[0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
    step++;
  endtask

  task automatic model_step(input logic rst, input logic en, input logic [1:0] mo,
                            input logic dr, input logic si, input logic [N-1:0] dd);
    if (rst) begin
      m_q = '0; m_c = '0; m_f = 1'b0;
    end else if (!en) begin
      m_f = 1'b0;
    end else begin
      case (mo)
        2'b00, 2'b01: begin
          if (mo == 2'b00) m_q = dr ? {m_q[N-2:0], si} : {si, m_q[N-1:1]};
          else             m_q = dr ? {m_q[N-2:0], m_q[N-1]} : {m_q[0], m_q[N-1:1]};
          if (m_c == CW'(N - 1)) begin
            m_c = '0; m_f = 1'b1;
          end else begin
            m_c = m_c + CW'(1); m_f = 1'b0;
          end
        end
        2'b10: begin
          m_q = dd; m_c = '0; m_f = 1'b0;
        end
        default: m_f = 1'b0;
      endcase
    end
  endtask

  initial begin
    reset = 1'b1; enb = 1'b0; modo = 2'b11; dir = 1'b0; s_in = 1'b0; d = '0;

    // Reset dominates a load
    add_vec(1,1,2'b10,0,0,4'b1111, 4'b0000,0,0);
    add_vec(1,1,2'b10,0,0,4'b1111, 4'b0000,0,0);
    // Load then right shift with s_in=1
    add_vec(0,1,2'b10,0,1,4'b1011, 4'b1011,0,0);
    add_vec(0,1,2'b00,0,1,4'b0000, 4'b1101,1,0);
    add_vec(0,1,2'b00,0,1,4'b0000, 4'b1110,2,0);
    add_vec(0,1,2'b00,0,1,4'b0000, 4'b1111,3,0);
    add_vec(0,1,2'b00,0,1,4'b0000, 4'b1111,0,1);
    add_vec(0,1,2'b11,0,1,4'b0000, 4'b1111,0,0);
    // Left rotate of 1011
    add_vec(0,1,2'b10,1,0,4'b1011, 4'b1011,0,0);
    add_vec(0,1,2'b01,1,0,4'b0000, 4'b0111,1,0);
    add_vec(0,1,2'b01,1,0,4'b0000, 4'b1110,2,0);
    add_vec(0,1,2'b01,1,0,4'b0000, 4'b1101,3,0);
    add_vec(0,1,2'b01,1,0,4'b0000, 4'b1011,0,1);
    add_vec(0,1,2'b11,1,0,4'b0000, 4'b1011,0,0);

    foreach (vecs[i])
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].modo, vecs[i].dir,
                    vecs[i].sin, vecs[i].d, vecs[i].eq, vecs[i].ec, vecs[i].ef);

    // Enable low and modo hold freeze a frame mid-way
    applyStimulus(0,1,2'b10,0,0,4'b1011, 4'b1011,0,0);
    applyStimulus(0,1,2'b00,0,0,4'b0000, 4'b0101,1,0);
    applyStimulus(0,1,2'b00,0,0,4'b0000, 4'b0010,2,0);
    for (int k = 0; k < 3; k++)
      applyStimulus(0,0,2'b00,0,1,4'b1111, 4'b0010,2,0);
    applyStimulus(0,1,2'b11,0,1,4'b1111, 4'b0010,2,0);
    applyStimulus(0,1,2'b00,0,1,4'b0000, 4'b1001,3,0);
    applyStimulus(0,1,2'b00,0,1,4'b0000, 4'b1100,0,1);

    // Reset aborts a frame at cuenta=3; next frame needs 4 full shifts
    applyStimulus(0,1,2'b00,0,0,4'b0000, 4'b0110,1,0);
    applyStimulus(0,1,2'b00,0,0,4'b0000, 4'b0011,2,0);
    applyStimulus(0,1,2'b00,0,0,4'b0000, 4'b0001,3,0);
    applyStimulus(1,1,2'b00,0,1,4'b0000, 4'b0000,0,0);
    applyStimulus(0,1,2'b00,0,1,4'b0000, 4'b1000,1,0);
    applyStimulus(0,1,2'b00,0,1,4'b0000, 4'b1100,2,0);
    applyStimulus(0,1,2'b00,0,1,4'b0000, 4'b1110,3,0);
    applyStimulus(0,1,2'b00,0,1,4'b0000, 4'b1111,0,1);

    // Load interrupts a frame at cuenta=3
    applyStimulus(0,1,2'b00,1,0,4'b0000, 4'b1110,1,0);
    applyStimulus(0,1,2'b00,1,0,4'b0000, 4'b1100,2,0);
    applyStimulus(0,1,2'b00,1,0,4'b0000, 4'b1000,3,0);
    applyStimulus(0,1,2'b10,1,0,4'b0101, 4'b0101,0,0);
    applyStimulus(0,1,2'b11,1,0,4'b0000, 4'b0101,0,0);

    // Mixing dir and shift/rotate within one frame keeps counting
    applyStimulus(0,1,2'b01,0,0,4'b0000, 4'b1010,1,0);
    applyStimulus(0,1,2'b00,1,1,4'b0000, 4'b0101,2,0);
    applyStimulus(0,1,2'b01,1,0,4'b0000, 4'b1010,3,0);
    applyStimulus(0,1,2'b00,0,0,4'b0000, 4'b0101,0,1);
    applyStimulus(0,0,2'b00,0,0,4'b0000, 4'b0101,0,0);

    // Randomised run against the model, starting from reset
    model_step(1,1,2'b00,0,0,4'b0000);
    applyStimulus(1,1,2'b00,0,0,4'b0000, m_q,m_c,m_f);
    for (int k = 0; k < 300; k++) begin
      logic          r_rst, r_en, r_dir, r_sin;
      logic [1:0]    r_modo;
      logic [N-1:0]  r_d;
      r_rst  = ($urandom_range(0, 39) == 0);
      r_en   = ($urandom_range(0, 7) != 0);
      r_modo = ($urandom_range(0, 9) < 7) ? 2'($urandom_range(0, 1))
                                          : 2'($urandom_range(2, 3));
      r_dir  = 1'($urandom_range(0, 1));
      r_sin  = 1'($urandom_range(0, 1));
      r_d    = N'($urandom);
      model_step(r_rst, r_en, r_modo, r_dir, r_sin, r_d);
      applyStimulus(r_rst, r_en, r_modo, r_dir, r_sin, r_d, m_q, m_c, m_f);
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
